// File: rtl/fell_chk_pkg.sv
// Shared types and default widths for the falling-edge window checker.
package fell_chk_pkg;

    localparam int unsigned TMO_W_DEF = 8;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } chk_state_t;

endpackage

// File: rtl/edge_sampler.sv
// Sampled-edge detector: $rose/$fell semantics on a single-bit signal.
module edge_sampler (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    output logic rose_now,
    output logic fell_now,
    output logic rose_pulse,
    output logic fell_pulse
);

    logic a_q;
    logic hist_valid;

    // Edges need a previous sample; the first sample after reset has none.
    assign rose_now = hist_valid & ~a_q &  a;
    assign fell_now = hist_valid &  a_q & ~a;

    // Sample history and registered edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= 1'b0;
            hist_valid <= 1'b0;
            rose_pulse <= 1'b0;
            fell_pulse <= 1'b0;
        end else begin
            a_q        <= a;
            hist_valid <= 1'b1;
            rose_pulse <= rose_now;
            fell_pulse <= fell_now;
        end
    end

endmodule

// File: rtl/fell_window_checker.sv
// Checks that a falling edge of a arrives within a programmable window after start.
module fell_window_checker
    import fell_chk_pkg::*;
#(
    parameter int unsigned TMO_W = TMO_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             a,
    input  logic             start,
    input  logic [TMO_W-1:0] timeout,
    input  logic             clr_cnt,
    output logic             rose_pulse,
    output logic             fell_pulse,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic             start_drop,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    chk_state_t       state_q;
    chk_state_t       state_d;
    logic [TMO_W-1:0] win_q;
    logic [TMO_W-1:0] win_d;
    logic             pass_d;
    logic             fail_d;
    logic             drop_d;
    logic             fell_now;
    // Rising-edge detection is not needed by the window check itself.
    logic             rose_now_unused;

    edge_sampler u_edge_sampler (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .rose_now   (rose_now_unused),
        .fell_now   (fell_now),
        .rose_pulse (rose_pulse),
        .fell_pulse (fell_pulse)
    );

    // Next-state, window countdown and event decisions.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // A fall on the arming edge is ignored: window opens next edge.
                if (en && start) begin
                    if (timeout != '0) begin
                        state_d = ARMED;
                        win_d   = timeout;
                    end else begin
                        fail_d = 1'b1;
                    end
                end
            end
            ARMED: begin
                drop_d = start;
                if (!en) begin
                    state_d = IDLE;
                    win_d   = '0;
                end else if (fell_now) begin
                    pass_d  = 1'b1;
                    state_d = IDLE;
                    win_d   = '0;
                end else if (win_q == TMO_W'(1)) begin
                    fail_d  = 1'b1;
                    state_d = IDLE;
                    win_d   = '0;
                end else begin
                    win_d = win_q - TMO_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                win_d   = '0;
            end
        endcase
    end

    // FSM state, window count and registered status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            win_q      <= '0;
            busy       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            start_drop <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            busy       <= (state_d == ARMED);
            pass       <= pass_d;
            fail       <= fail_d;
            start_drop <= drop_d;
        end
    end

    // Saturating event counters; a clear on the same edge drops the event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (clr_cnt) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            if (pass_d && (pass_cnt != '1)) begin
                pass_cnt <= pass_cnt + CNT_W'(1);
            end
            if (fail_d && (fail_cnt != '1)) begin
                fail_cnt <= fail_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fell_window_checker.sv
// Scoreboard bench for fell_window_checker (default widths plus a 2-bit counter instance).
module tb_fell_window_checker;

    localparam logic [5:0] E_0 = 6'b000000;
    localparam logic [5:0] E_R = 6'b100000;
    localparam logic [5:0] E_F = 6'b010000;
    localparam logic [5:0] E_B = 6'b001000;
    localparam logic [5:0] E_P = 6'b000100;
    localparam logic [5:0] E_X = 6'b000010;
    localparam logic [5:0] E_D = 6'b000001;

    typedef struct packed {
        logic       a;
        logic       st;
        logic       en;
        logic [7:0] tmo;
        logic       clr;
        logic [5:0] exp;
    } row_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        a = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  timeout = 8'd0;
    logic        clr_cnt = 1'b0;

    logic        rose_pulse, fell_pulse, busy, pass, fail, start_drop;
    logic [15:0] pass_cnt, fail_cnt;
    logic        rose_pulse_2, fell_pulse_2, busy_2, pass_2, fail_2, start_drop_2;
    logic [1:0]  pass_cnt_2, fail_cnt_2;
    logic [5:0]  obs, obs2;

    int          checks = 0;
    int          errors = 0;
    int          exp_pass = 0;
    int          exp_fail = 0;
    logic [5:0]  exp_q [$];

    assign obs  = {rose_pulse, fell_pulse, busy, pass, fail, start_drop};
    assign obs2 = {rose_pulse_2, fell_pulse_2, busy_2, pass_2, fail_2, start_drop_2};

    always #5 clk = ~clk;

    fell_window_checker u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .start(start),
        .timeout(timeout), .clr_cnt(clr_cnt),
        .rose_pulse(rose_pulse), .fell_pulse(fell_pulse), .busy(busy),
        .pass(pass), .fail(fail), .start_drop(start_drop),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    fell_window_checker #(.TMO_W(8), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .start(start),
        .timeout(timeout), .clr_cnt(clr_cnt),
        .rose_pulse(rose_pulse_2), .fell_pulse(fell_pulse_2), .busy(busy_2),
        .pass(pass_2), .fail(fail_2), .start_drop(start_drop_2),
        .pass_cnt(pass_cnt_2), .fail_cnt(fail_cnt_2)
    );

    function automatic row_t mk(input logic ai, input logic st, input logic eni,
                                input logic [7:0] tmo, input logic clr, input logic [5:0] ex);
        row_t r;
        r.a = ai; r.st = st; r.en = eni; r.tmo = tmo; r.clr = clr; r.exp = ex;
        return r;
    endfunction

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    // Apply one cycle of stimulus and queue the outputs expected after the edge.
    task automatic drive(input row_t r);
        a = r.a; start = r.st; en = r.en; timeout = r.tmo; clr_cnt = r.clr;
        exp_q.push_back(r.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] e;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(E_0);
        repeat (2) @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({obs, obs2} !== {e, e}) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%b required %b", obs, obs2, e);
        end
        checks++;
        if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || pass_cnt_2 !== 2'd0 || fail_cnt_2 !== 2'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d %0d %0d %0d required 0", pass_cnt, fail_cnt, pass_cnt_2, fail_cnt_2);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_edges();
        row_t rows [5];
        logic [5:0] e;
        rows = '{mk(1,0,0,0,0,E_0), mk(1,0,0,0,0,E_0), mk(0,0,0,0,0,E_F),
                 mk(1,0,0,0,0,E_R), mk(0,0,0,0,0,E_F)};
        for (int i = 0; i < 5; i++) begin
            drive(rows[i]);
            e = exp_q.pop_front();
            checks++;
            if ({obs, obs2} !== {e, e}) begin
                errors++;
                $display("FAIL edges_cyc%0d: got %b/%b required %b", i, obs, obs2, e);
            end
        end
    endtask

    task automatic test_pass();
        row_t rows [6];
        logic [5:0] e;
        rows = '{mk(1,0,1,0,0,E_R), mk(1,1,1,4,0,E_B), mk(1,0,1,0,0,E_B),
                 mk(1,0,1,0,0,E_B), mk(0,0,1,0,0,E_F|E_P), mk(0,0,1,0,0,E_0)};
        for (int i = 0; i < 6; i++) begin
            drive(rows[i]);
            e = exp_q.pop_front();
            checks++;
            if ({obs, obs2} !== {e, e}) begin
                errors++;
                $display("FAIL pass_cyc%0d: got %b/%b required %b", i, obs, obs2, e);
            end
            if (i == 4) exp_pass++;
        end
        checks++;
        if (pass_cnt !== 16'(exp_pass) || pass_cnt_2 !== 2'(sat(exp_pass, 3)) ||
            fail_cnt !== 16'(exp_fail) || fail_cnt_2 !== 2'(sat(exp_fail, 3))) begin
            errors++;
            $display("FAIL pass_counters: got pass=%0d/%0d fail=%0d/%0d required pass=%0d fail=%0d",
                     pass_cnt, pass_cnt_2, fail_cnt, fail_cnt_2, exp_pass, exp_fail);
        end
    endtask

    task automatic test_fail();
        row_t rows [6];
        logic [5:0] e;
        rows = '{mk(1,0,1,0,0,E_R), mk(1,1,1,3,0,E_B), mk(1,0,1,0,0,E_B),
                 mk(1,0,1,0,0,E_B), mk(1,0,1,0,0,E_X), mk(0,0,1,0,0,E_F)};
        for (int i = 0; i < 6; i++) begin
            drive(rows[i]);
            e = exp_q.pop_front();
            checks++;
            if ({obs, obs2} !== {e, e}) begin
                errors++;
                $display("FAIL fail_cyc%0d: got %b/%b required %b", i, obs, obs2, e);
            end
            if (i == 4) exp_fail++;
        end
        checks++;
        if (pass_cnt !== 16'(exp_pass) || pass_cnt_2 !== 2'(sat(exp_pass, 3)) ||
            fail_cnt !== 16'(exp_fail) || fail_cnt_2 !== 2'(sat(exp_fail, 3))) begin
            errors++;
            $display("FAIL fail_counters: got pass=%0d/%0d fail=%0d/%0d required pass=%0d fail=%0d",
                     pass_cnt, pass_cnt_2, fail_cnt, fail_cnt_2, exp_pass, exp_fail);
        end
    endtask

    task automatic test_zero_and_drop();
        row_t rows [8];
        logic [5:0] e;
        // Zero timeout fails at once; the dropped start carries a timeout of 1 that must not relatch.
        rows = '{mk(0,1,1,0,0,E_X), mk(1,0,1,0,0,E_R), mk(1,1,1,5,0,E_B),
                 mk(1,0,1,0,0,E_B), mk(1,1,1,1,0,E_B|E_D), mk(1,0,1,0,0,E_B),
                 mk(1,0,1,0,0,E_B), mk(1,0,1,0,0,E_X)};
        for (int i = 0; i < 8; i++) begin
            drive(rows[i]);
            e = exp_q.pop_front();
            checks++;
            if ({obs, obs2} !== {e, e}) begin
                errors++;
                $display("FAIL zero_drop_cyc%0d: got %b/%b required %b", i, obs, obs2, e);
            end
            if (i == 0 || i == 7) exp_fail++;
        end
        checks++;
        if (pass_cnt !== 16'(exp_pass) || pass_cnt_2 !== 2'(sat(exp_pass, 3)) ||
            fail_cnt !== 16'(exp_fail) || fail_cnt_2 !== 2'(sat(exp_fail, 3))) begin
            errors++;
            $display("FAIL zero_drop_counters: got pass=%0d/%0d fail=%0d/%0d required pass=%0d fail=%0d",
                     pass_cnt, pass_cnt_2, fail_cnt, fail_cnt_2, exp_pass, exp_fail);
        end
    endtask

    task automatic test_abort();
        row_t rows [7];
        logic [5:0] e;
        rows = '{mk(1,1,1,4,0,E_B), mk(1,0,1,0,0,E_B), mk(1,0,0,0,0,E_0),
                 mk(0,0,1,0,0,E_F), mk(1,0,1,0,0,E_R), mk(1,1,1,8,0,E_B),
                 mk(1,0,1,0,0,E_B)};
        for (int i = 0; i < 7; i++) begin
            drive(rows[i]);
            e = exp_q.pop_front();
            checks++;
            if ({obs, obs2} !== {e, e}) begin
                errors++;
                $display("FAIL abort_cyc%0d: got %b/%b required %b", i, obs, obs2, e);
            end
        end
        // Asynchronous reset mid-check clears everything without waiting for an edge.
        #2;
        rst_n = 1'b0;
        #1;
        exp_pass = 0;
        exp_fail = 0;
        checks++;
        if ({obs, obs2} !== 12'd0) begin
            errors++;
            $display("FAIL abort_async_reset: got %b/%b required 000000", obs, obs2);
        end
        checks++;
        if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || pass_cnt_2 !== 2'd0 || fail_cnt_2 !== 2'd0) begin
            errors++;
            $display("FAIL abort_reset_counters: got %0d %0d %0d %0d required 0", pass_cnt, fail_cnt, pass_cnt_2, fail_cnt_2);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sat_and_clear();
        row_t rows [3];
        logic [5:0] e;
        drive(mk(0,0,1,0,0,E_0));
        e = exp_q.pop_front();
        checks++;
        if ({obs, obs2} !== {e, e}) begin
            errors++;
            $display("FAIL sat_first_sample: got %b/%b required %b", obs, obs2, e);
        end
        rows = '{mk(1,0,1,0,0,E_R), mk(1,1,1,2,0,E_B), mk(0,0,1,0,0,E_F|E_P)};
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 3; i++) begin
                drive(rows[i]);
                e = exp_q.pop_front();
                checks++;
                if ({obs, obs2} !== {e, e}) begin
                    errors++;
                    $display("FAIL sat_pass%0d_cyc%0d: got %b/%b required %b", n, i, obs, obs2, e);
                end
            end
            exp_pass++;
        end
        checks++;
        if (pass_cnt !== 16'd5 || pass_cnt_2 !== 2'd3 || fail_cnt !== 16'd0 || fail_cnt_2 !== 2'd0) begin
            errors++;
            $display("FAIL sat_counters: got pass=%0d/%0d fail=%0d/%0d required pass=5/3 fail=0/0",
                     pass_cnt, pass_cnt_2, fail_cnt, fail_cnt_2);
        end
        // Clear on the same edge as a pass: the clear wins and the pass is not counted.
        rows[2].clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(rows[i]);
            e = exp_q.pop_front();
            checks++;
            if ({obs, obs2} !== {e, e}) begin
                errors++;
                $display("FAIL clr_cyc%0d: got %b/%b required %b", i, obs, obs2, e);
            end
        end
        exp_pass = 0;
        checks++;
        if (pass_cnt !== 16'(exp_pass) || pass_cnt_2 !== 2'(exp_pass) || fail_cnt !== 16'd0 || fail_cnt_2 !== 2'd0) begin
            errors++;
            $display("FAIL clr_counters: got pass=%0d/%0d fail=%0d/%0d required 0",
                     pass_cnt, pass_cnt_2, fail_cnt, fail_cnt_2);
        end
        drive(mk(0,0,1,0,0,E_0));
        e = exp_q.pop_front();
        checks++;
        if ({obs, obs2} !== {e, e}) begin
            errors++;
            $display("FAIL clr_idle: got %b/%b required %b", obs, obs2, e);
        end
    endtask

    initial begin
        test_reset();
        test_edges();
        test_pass();
        test_fail();
        test_zero_and_drop();
        test_abort();
        test_sat_and_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
